// File: rtl/sort_pkg.sv
// Shared types and constants for the sorted-packet checker.
// FSM states, error-bit positions, LFSR taps and the default-width result record.
package sort_pkg;

    typedef enum logic {
        IDLE_S   = 1'b0,
        IN_PKT_S = 1'b1
    } state_t;

    localparam int ORDER_ERR   = 0;
    localparam int FRAMING_ERR = 1;
    localparam int LEN_ERR     = 2;

    // Fibonacci taps 16,14,13,11 on a left-shifting register (bits 15,13,12,10)
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int DEF_LEN_W = 9;
    localparam int DEF_SUM_W = 17;

    typedef struct packed {
        logic [DEF_LEN_W-1:0] len;
        logic [DEF_SUM_W-1:0] sum;
        logic                 sorted;
        logic [2:0]           err;
    } pkt_result_t;

endpackage

// File: rtl/lfsr_ready_gen.sv
// Registered sink-ready source: constant 1, or bit 0 of a free-running 16-bit LFSR.
// Zero inputs reach ready_o combinationally; the LFSR advances every cycle.
module lfsr_ready_gen
    import sort_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic clk_i,
    input  logic arst_i,
    input  logic en_i,
    output logic ready_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_nxt;

    assign lfsr_nxt = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};

    // ready is loaded from the next LFSR value so it tracks the current LFSR[0]
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            lfsr_q  <= SEED;
            ready_o <= 1'b0;
        end else begin
            lfsr_q  <= lfsr_nxt;
            ready_o <= en_i ? lfsr_nxt[0] : 1'b1;
        end
    end

endmodule

// File: rtl/sorted_pkt_checker.sv
// Avalon-ST sink checking beat order, framing and length; reports one result per packet.
// Result appears the cycle after eop acceptance; ready comes from lfsr_ready_gen.
module sorted_pkt_checker
    import sort_pkg::*;
#(
    parameter int          DWIDTH      = 8,
    parameter int          MAX_PKT_LEN = 256,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    localparam int         LEN_W       = $clog2(MAX_PKT_LEN + 1),
    localparam int         SUM_W       = DWIDTH + LEN_W
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic [DWIDTH-1:0] snk_data_i,
    input  logic              snk_startofpacket_i,
    input  logic              snk_endofpacket_i,
    input  logic              snk_valid_i,
    output logic              snk_ready_o,
    input  logic              bp_en_i,
    output logic              pkt_done_o,
    output logic [LEN_W-1:0]  pkt_len_o,
    output logic [SUM_W-1:0]  pkt_sum_o,
    output logic              pkt_sorted_o,
    output logic [2:0]        pkt_err_o,
    output logic [15:0]       pkt_cnt_o,
    output logic [15:0]       err_cnt_o
);

    typedef struct packed {
        logic [LEN_W-1:0] len;
        logic [SUM_W-1:0] sum;
        logic             sorted;
        logic [2:0]       err;
    } res_t;

    localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_PKT_LEN + 1);
    localparam logic [LEN_W-1:0] LEN_LIM = LEN_W'(MAX_PKT_LEN);

    state_t            state_q, state_nxt;
    logic [LEN_W-1:0]  len_q, len_nxt, len_inc;
    logic [SUM_W-1:0]  sum_q, sum_nxt, sum_add, data_sum;
    logic [DWIDTH-1:0] prev_q, prev_nxt;
    logic              sorted_q, sorted_nxt, sorted_add;
    logic              frm_q, frm_nxt;
    logic              orphan_q, orphan_nxt;
    logic              a_vld, b_vld, out_vld;
    res_t              a_res, b_res, out_res;
    logic              skid_vld_q, skid_vld_nxt;
    res_t              skid_q, skid_nxt;
    res_t              res_q;
    logic              done_q;
    logic [15:0]       pkt_cnt_q, err_cnt_q;
    logic              accept;

    lfsr_ready_gen #(.SEED(LFSR_SEED)) u_ready (
        .clk_i   (clk_i),
        .arst_i  (arst_i),
        .en_i    (bp_en_i),
        .ready_o (snk_ready_o)
    );

    assign accept     = snk_valid_i & snk_ready_o;
    assign len_inc    = (len_q == LEN_SAT) ? LEN_SAT : len_q + LEN_W'(1);
    assign data_sum   = SUM_W'(snk_data_i);
    assign sum_add    = sum_q + data_sum;
    assign sorted_add = sorted_q & (snk_data_i >= prev_q);

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) state_q <= IDLE_S;
        else        state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        if (accept) begin
            case (state_q)
                IDLE_S:   if (snk_startofpacket_i && !snk_endofpacket_i) state_nxt = IN_PKT_S;
                IN_PKT_S: if (snk_endofpacket_i) state_nxt = IDLE_S;
                default:  state_nxt = IDLE_S;
            endcase
        end
    end

    always_comb begin
        len_nxt    = len_q;
        sum_nxt    = sum_q;
        prev_nxt   = prev_q;
        sorted_nxt = sorted_q;
        frm_nxt    = frm_q;
        orphan_nxt = orphan_q;
        a_vld      = 1'b0;
        a_res      = '0;
        b_vld      = 1'b0;
        b_res      = '0;
        if (accept) begin
            case (state_q)
                IDLE_S: begin
                    if (!snk_startofpacket_i) begin
                        orphan_nxt = 1'b1;
                    end else if (snk_endofpacket_i) begin
                        a_vld                  = 1'b1;
                        a_res.len              = LEN_W'(1);
                        a_res.sum              = data_sum;
                        a_res.sorted           = 1'b1;
                        a_res.err[FRAMING_ERR] = orphan_q;
                        orphan_nxt             = 1'b0;
                    end else begin
                        len_nxt    = LEN_W'(1);
                        sum_nxt    = data_sum;
                        prev_nxt   = snk_data_i;
                        sorted_nxt = 1'b1;
                        frm_nxt    = orphan_q;
                        orphan_nxt = 1'b0;
                    end
                end
                IN_PKT_S: begin
                    if (!snk_startofpacket_i) begin
                        len_nxt    = len_inc;
                        sum_nxt    = sum_add;
                        prev_nxt   = snk_data_i;
                        sorted_nxt = sorted_add;
                        if (snk_endofpacket_i) begin
                            a_vld                  = 1'b1;
                            a_res.len              = len_inc;
                            a_res.sum              = sum_add;
                            a_res.sorted           = sorted_add;
                            a_res.err[LEN_ERR]     = len_inc > LEN_LIM;
                            a_res.err[FRAMING_ERR] = frm_q;
                            a_res.err[ORDER_ERR]   = ~sorted_add;
                        end
                    end else begin
                        // early sop: close what we have, the sop beat opens the next packet
                        a_vld                  = 1'b1;
                        a_res.len              = len_q;
                        a_res.sum              = sum_q;
                        a_res.sorted           = sorted_q;
                        a_res.err[LEN_ERR]     = len_q > LEN_LIM;
                        a_res.err[FRAMING_ERR] = 1'b1;
                        a_res.err[ORDER_ERR]   = ~sorted_q;
                        len_nxt    = LEN_W'(1);
                        sum_nxt    = data_sum;
                        prev_nxt   = snk_data_i;
                        sorted_nxt = 1'b1;
                        frm_nxt    = 1'b0;
                        if (snk_endofpacket_i) begin
                            b_vld        = 1'b1;
                            b_res.len    = LEN_W'(1);
                            b_res.sum    = data_sum;
                            b_res.sorted = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Skid holds one pending result; two-result cycles always land in IDLE_S
    // so at most one new result can arrive while it drains.
    always_comb begin
        out_vld      = 1'b0;
        out_res      = '0;
        skid_vld_nxt = 1'b0;
        skid_nxt     = skid_q;
        if (skid_vld_q) begin
            out_vld      = 1'b1;
            out_res      = skid_q;
            skid_vld_nxt = a_vld;
            skid_nxt     = a_res;
        end else if (a_vld) begin
            out_vld      = 1'b1;
            out_res      = a_res;
            skid_vld_nxt = b_vld;
            skid_nxt     = b_res;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            len_q      <= '0;
            sum_q      <= '0;
            prev_q     <= '0;
            sorted_q   <= 1'b0;
            frm_q      <= 1'b0;
            orphan_q   <= 1'b0;
            skid_vld_q <= 1'b0;
            skid_q     <= '0;
            res_q      <= '0;
            done_q     <= 1'b0;
            pkt_cnt_q  <= '0;
            err_cnt_q  <= '0;
        end else begin
            len_q      <= len_nxt;
            sum_q      <= sum_nxt;
            prev_q     <= prev_nxt;
            sorted_q   <= sorted_nxt;
            frm_q      <= frm_nxt;
            orphan_q   <= orphan_nxt;
            skid_vld_q <= skid_vld_nxt;
            skid_q     <= skid_nxt;
            done_q     <= out_vld;
            if (out_vld) begin
                res_q     <= out_res;
                pkt_cnt_q <= pkt_cnt_q + 16'd1;
                if (((|out_res.err) || !out_res.sorted) && (err_cnt_q != 16'hFFFF))
                    err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign pkt_done_o   = done_q;
    assign pkt_len_o    = res_q.len;
    assign pkt_sum_o    = res_q.sum;
    assign pkt_sorted_o = res_q.sorted;
    assign pkt_err_o    = res_q.err;
    assign pkt_cnt_o    = pkt_cnt_q;
    assign err_cnt_o    = err_cnt_q;

endmodule

// File: tb/tb_sorted_pkt_checker.sv
// Directed bench for sorted_pkt_checker: drives inputs on the falling edge and
// checks registered results on the falling edge after each eop acceptance.
module tb_sorted_pkt_checker;

    logic        clk = 1'b0;
    logic        arst;
    logic [7:0]  data;
    logic        sop, eop, valid;
    logic        ready;
    logic        bp_en;
    logic        done;
    logic [8:0]  len;
    logic [16:0] sum;
    logic        sorted;
    logic [2:0]  err;
    logic [15:0] pkt_cnt, err_cnt;

    int n_cmp  = 0;
    int n_err  = 0;
    int stalls = 0;

    always #5 clk = ~clk;

    sorted_pkt_checker #(.DWIDTH(8), .MAX_PKT_LEN(256), .LFSR_SEED(16'hACE1)) dut (
        .clk_i               (clk),
        .arst_i              (arst),
        .snk_data_i          (data),
        .snk_startofpacket_i (sop),
        .snk_endofpacket_i   (eop),
        .snk_valid_i         (valid),
        .snk_ready_o         (ready),
        .bp_en_i             (bp_en),
        .pkt_done_o          (done),
        .pkt_len_o           (len),
        .pkt_sum_o           (sum),
        .pkt_sorted_o        (sorted),
        .pkt_err_o           (err),
        .pkt_cnt_o           (pkt_cnt),
        .err_cnt_o           (err_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after the beat is taken.
    task automatic beat(input logic [7:0] d, input logic s, input logic e);
        int t;
        t     = 0;
        valid = 1'b1;
        data  = d;
        sop   = s;
        eop   = e;
        while (!ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        stalls += t;
        if (t >= 1000) begin
            n_cmp++;
            n_err++;
            $error("FAIL beat_timeout: observed=ready stuck low expected=beat accepted");
        end
        @(negedge clk);
    endtask

    task automatic idle();
        valid = 1'b0;
        sop   = 1'b0;
        eop   = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_res(input string tag, input int l, input int s, input logic so,
                             input logic [2:0] e, input int pc, input int ec);
        check({tag, ".done"},    done,    1);
        check({tag, ".len"},     len,     l);
        check({tag, ".sum"},     sum,     s);
        check({tag, ".sorted"},  sorted,  so);
        check({tag, ".err"},     err,     e);
        check({tag, ".pkt_cnt"}, pkt_cnt, pc);
        check({tag, ".err_cnt"}, err_cnt, ec);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed=simulation still running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        arst  = 1'b1;
        data  = '0;
        sop   = 1'b0;
        eop   = 1'b0;
        valid = 1'b0;
        bp_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst.ready",   ready,   0);
        check("rst.done",    done,    0);
        check("rst.len",     len,     0);
        check("rst.pkt_cnt", pkt_cnt, 0);
        check("rst.err_cnt", err_cnt, 0);
        arst = 1'b0;
        @(negedge clk);
        check("post_rst.ready", ready, 1);

        // ascending packet
        beat(8'd1, 1, 0); beat(8'd2, 0, 0); beat(8'd2, 0, 0); beat(8'd5, 0, 0); beat(8'd9, 0, 1);
        check_res("p1", 5, 19, 1, 3'b000, 1, 0);
        idle();
        check("p1.pulse_end", done, 0);
        check("p1.hold_len",  len,  5);

        // out-of-order packet
        beat(8'd4, 1, 0); beat(8'd3, 0, 0); beat(8'd7, 0, 1);
        check_res("p2", 3, 14, 0, 3'b001, 2, 1);
        idle();

        // single beat
        beat(8'hFF, 1, 1);
        check_res("p3", 1, 255, 1, 3'b000, 3, 1);
        idle();
        check("p3.pulse_end", done, 0);

        // early sop with eop: two back-to-back results
        beat(8'd1, 1, 0); beat(8'd2, 0, 0); beat(8'd0, 1, 1);
        check_res("p4a", 2, 3, 1, 3'b010, 4, 2);
        idle();
        check_res("p4b", 1, 0, 1, 3'b000, 5, 2);
        idle();
        check("p4.pulse_end", done, 0);

        // orphan beat flags the following packet
        beat(8'd7, 0, 0);
        idle();
        check("orphan.no_done", done,    0);
        check("orphan.pkt_cnt", pkt_cnt, 5);
        beat(8'd1, 1, 0); beat(8'd2, 0, 1);
        check_res("p5", 2, 3, 1, 3'b010, 6, 3);
        idle();

        // backpressure: 256-beat ascending packet
        bp_en  = 1'b1;
        idle();
        stalls = 0;
        for (int i = 0; i < 256; i++) beat(8'(i), i == 0, i == 255);
        check_res("p256", 256, 32640, 1, 3'b000, 7, 3);
        check("p256.stalled", stalls > 0, 1);
        idle();

        // 257 beats: length error
        for (int i = 0; i < 256; i++) beat(8'(i), i == 0, 1'b0);
        beat(8'd255, 0, 1);
        check_res("p257", 257, 32895, 1, 3'b100, 8, 4);
        idle();

        // reset mid-packet
        bp_en = 1'b0;
        beat(8'd1, 1, 0); beat(8'd2, 0, 0); beat(8'd3, 0, 0);
        valid = 1'b0;
        arst  = 1'b1;
        #1;
        check("midrst.ready",   ready,   0);
        check("midrst.done",    done,    0);
        check("midrst.pkt_cnt", pkt_cnt, 0);
        check("midrst.err_cnt", err_cnt, 0);
        @(negedge clk);
        arst = 1'b0;
        idle();
        check("midrst.no_done", done, 0);
        beat(8'd5, 1, 0); beat(8'd6, 0, 1);
        check_res("p6", 2, 11, 1, 3'b000, 1, 0);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
